weight_stream_replay_buffer: RTL and testbench
==============================================

WEIGHT_STREAM_REPLAY_BUFFER -- requirements
Module: weight_stream_replay_buffer

Interface
REQ-001 SHALL have parameter WEIGHT_PRECISION_0, default 16: bit width of one weight element.
REQ-002 SHALL have parameter WEIGHT_PARALLELISM_DIM_0, default 1: elements per beat along dim 0.
REQ-003 SHALL have parameter WEIGHT_PARALLELISM_DIM_1, default 1: elements per beat along dim 1; P = DIM_0*DIM_1 elements per beat.
REQ-004 SHALL have parameter DEPTH, default 32: beats per weight tile (>=2).
REQ-005 SHALL have parameter REPEAT, default 4: number of times each tile is emitted downstream (>=1).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port data_in, input, P x WEIGHT_PRECISION_0 array: weight beat from the upstream weight source.
REQ-009 SHALL have port data_in_valid, input, 1: upstream beat valid.
REQ-010 SHALL have port data_in_ready, output, 1: buffer accepts the upstream beat.
REQ-011 SHALL have port data_out, output, P x WEIGHT_PRECISION_0 array: weight beat to the downstream linear stage.
REQ-012 SHALL have port data_out_valid, output, 1: downstream beat valid.
REQ-013 SHALL have port data_out_ready, input, 1: downstream accepts the beat.
REQ-014 SHALL have port tile_done, output, 1: one-cycle pulse when all REPEAT passes of a tile have been delivered.

Function
REQ-015 SHALL hold DEPTH x P x WEIGHT_PRECISION_0 bits of tile storage; storage SHALL NOT be reset.
REQ-016 SHALL implement a two-state FSM: FILL (pass 0; accept, store and forward) and REPLAY (passes 1..REPEAT-1 from storage).
REQ-017 SHALL drive data_out/data_out_valid from one output register; a beat loads it when the register is empty or is being drained (advance = !data_out_valid || data_out_ready).
REQ-018 SHALL, in FILL, drive data_in_ready = advance combinationally; the handshake (data_in_valid && data_in_ready) writes data_in to storage[wr_ptr], loads the output register, and increments wr_ptr.
REQ-019 SHALL drive data_in_ready = 0 in REPLAY.
REQ-020 SHALL give a one-cycle latency: a beat accepted at edge t is presented on data_out with data_out_valid = 1 after edge t.
REQ-021 SHALL, on the FILL handshake at wr_ptr = DEPTH-1, wrap wr_ptr to 0 and enter REPLAY with rd_ptr = 0 and pass = 1 when REPEAT > 1, or stay in FILL when REPEAT = 1.
REQ-022 SHALL, in REPLAY, load storage[rd_ptr] into the output register on every cycle where advance is true, incrementing rd_ptr.
REQ-023 SHALL wrap rd_ptr to 0 at DEPTH-1 and increment pass; after the last beat of pass REPEAT-1 is loaded, the FSM SHALL return to FILL.
REQ-024 SHALL sustain one beat per cycle with no bubble across FILL->REPLAY, pass->pass and REPLAY->FILL boundaries, given continuous valid and ready.
REQ-025 SHALL hold data_out stable while data_out_valid && !data_out_ready.
REQ-026 SHALL clear data_out_valid after a drain handshake when no new beat loads: FILL with no upstream beat, or REPLAY already exhausted.
REQ-027 SHALL pulse tile_done for exactly one cycle, registered, in the cycle after the output handshake of beat DEPTH-1 of pass REPEAT-1.
REQ-028 SHALL size wr_ptr/rd_ptr as $clog2(DEPTH) bits and pass as $clog2(REPEAT)+1 bits; pointers SHALL never exceed DEPTH-1.

Reset
REQ-029 SHALL, while rst = 1 and without waiting for a clock edge, force: state = FILL, wr_ptr = rd_ptr = pass = 0, data_out = 0, data_out_valid = 0, tile_done = 0.
REQ-030 SHALL, on rst assertion mid-tile, discard any partial tile; after release the next upstream beat is treated as beat 0 of pass 0.
REQ-031 SHALL keep data_in_ready = 0 while rst = 1, and return it to 1 on the first cycle after release.

Verification
REQ-032 DEPTH=4, REPEAT=3, P=1, inputs 1,2,3,4, valid and ready held high -> outputs 1,2,3,4,1,2,3,4,1,2,3,4 on 12 consecutive cycles starting the cycle after the first accept; tile_done pulses once, the cycle after the 12th beat.
REQ-033 Same configuration, data_out_ready toggling 1,0,1,0 -> identical 12-value sequence; data_out stable during every stall; data_in_ready = 0 from the cycle after beat 4 is accepted until the 12th beat drains.
REQ-034 REPEAT=1, inputs 5,6,7,8 with data_in_valid low every other cycle -> outputs 5,6,7,8 only; data_out_valid low in the gap cycles; tile_done after 8; FSM never enters REPLAY.
REQ-035 Two back-to-back tiles, 1..4 then 9..12, REPEAT=2 -> 1..4,1..4,9..12,9..12; the second tile fully overwrites storage.
REQ-036 Assert rst during pass 1, beat 2 -> data_out_valid and data_out = 0 immediately without a clock edge; after release, input 20..23 -> output 20..23 (x REPEAT), no stale values.

Source files
------------

// File: rtl/weight_stream_replay_buffer.sv
// Weight tile replay buffer: forwards a DEPTH-beat tile once while storing it,
// then replays it from storage so every tile reaches the consumer REPEAT times.
module weight_stream_replay_buffer #(
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int DEPTH                    = 32,
  parameter int REPEAT                   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [WEIGHT_PRECISION_0-1:0] data_out [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1],
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          tile_done
);

  localparam int P  = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int W  = WEIGHT_PRECISION_0;
  localparam int BW = P * W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(REPEAT) + 1;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(REPEAT - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   pass_q, pass_d;
  logic [BW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            out_last_q, out_last_d;
  logic            tile_done_q, tile_done_d;
  logic [BW-1:0]   mem_q [DEPTH];

  logic [BW-1:0]   din_flat;
  logic            advance;
  logic            in_fire;
  logic            rep_fire;
  logic            last_wr;
  logic            last_rd;
  logic            last_pass;

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    assign din_flat[gi*W +: W] = data_in[gi];
    assign data_out[gi]        = dout_q[gi*W +: W];
  end

  assign data_out_valid = dout_valid_q;
  assign tile_done      = tile_done_q;

  assign advance   = !dout_valid_q || data_out_ready;
  assign last_wr   = (wr_ptr_q == LAST_PTR);
  assign last_rd   = (rd_ptr_q == LAST_PTR);
  assign last_pass = (pass_q == LAST_PASS);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          wr_ptr_d = last_wr ? '0 : wr_ptr_q + 1'b1;
          if (last_wr && (REPEAT > 1)) begin
            state_d  = REPLAY;
            rd_ptr_d = '0;
            pass_d   = CW'(1);
          end
        end
      end
      REPLAY: begin
        if (rep_fire) begin
          rd_ptr_d = last_rd ? '0 : rd_ptr_q + 1'b1;
          if (last_rd) begin
            pass_d = last_pass ? '0 : pass_q + 1'b1;
            if (last_pass) state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output logic: upstream is stalled for the whole replay phase
  always_comb begin
    data_in_ready = !rst && (state_q == FILL) && advance;
    in_fire       = data_in_valid && data_in_ready;
    rep_fire      = (state_q == REPLAY) && advance;
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    out_last_d   = out_last_q;
    if (in_fire) begin
      dout_d       = din_flat;
      dout_valid_d = 1'b1;
      out_last_d   = last_wr && (REPEAT == 1);
    end else if (rep_fire) begin
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
      out_last_d   = last_rd && last_pass;
    end else if (data_out_ready) begin
      dout_valid_d = 1'b0;
    end
    // out_last_q marks the final beat of the final pass currently held for output
    tile_done_d = dout_valid_q && data_out_ready && out_last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      out_last_q   <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      out_last_q   <= out_last_d;
      tile_done_q  <= tile_done_d;
    end
  end

  // Tile storage carries no reset; it is always rewritten before replay
  always_ff @(posedge clk) begin
    if (in_fire) mem_q[wr_ptr_q] <= din_flat;
  end

endmodule

// File: tb/tb_weight_stream_replay_buffer.sv
// Directed bench for weight_stream_replay_buffer: three instances with DEPTH=4
// and REPEAT of 3, 1 and 2, checked cycle by cycle against a small stream model.
module tb_weight_stream_replay_buffer;

  logic              clk;
  logic              rst;
  logic [2:0]        vin;
  logic [2:0]        rdy_in;
  logic [2:0][15:0]  din_w;
  logic [2:0][15:0]  dout_w;
  logic [2:0]        in_rdy_w;
  logic [2:0]        vout_w;
  logic [2:0]        td_w;

  int checks;
  int failures;
  int in_vec  [8];
  int exp_vec [16];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [15:0] di [1];
    logic [15:0] dq [1];
    assign di[0]     = din_w[gi];
    assign dout_w[gi] = dq[0];

    weight_stream_replay_buffer #(
      .WEIGHT_PRECISION_0      (16),
      .WEIGHT_PARALLELISM_DIM_0(1),
      .WEIGHT_PARALLELISM_DIM_1(1),
      .DEPTH                   (4),
      .REPEAT                  ((gi == 0) ? 3 : (gi == 1) ? 1 : 2)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (di),
      .data_in_valid (vin[gi]),
      .data_in_ready (in_rdy_w[gi]),
      .data_out      (dq),
      .data_out_valid(vout_w[gi]),
      .data_out_ready(rdy_in[gi]),
      .tile_done     (td_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Drives instance k with in_vec and checks against exp_vec until stop_at beats drain.
  task automatic run(input int k, input int rep, input int n_in, input int n_out,
                     input int stop_at, input int vmode, input int rmode);
    int   acc, loaded, drained, post;
    logic vm, td_m, rdy, vld, rpl, adv, ir_m, fire_in, fire_rp, drain;
    acc = 0; loaded = 0; drained = 0; post = 0;
    vm = 1'b0; td_m = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      rdy = (rmode == 0) ? 1'b1 : (cyc % 2 == 0);
      vld = (acc < n_in) && ((vmode == 0) || (cyc % 2 == 0));
      rdy_in[k] = rdy;
      vin[k]    = vld;
      din_w[k]  = vld ? 16'(in_vec[acc]) : 16'd0;
      #1;
      adv  = !vm || rdy;
      rpl  = (rep > 1) && (acc > 0) && (acc % 4 == 0) && (loaded < acc * rep);
      ir_m = !rpl && adv;
      check_val("out_valid", 32'(vout_w[k]), 32'(vm));
      if (vm) check_val("data_out", 32'(dout_w[k]), 32'(exp_vec[drained]));
      check_val("in_ready", 32'(in_rdy_w[k]), 32'(ir_m));
      check_val("tile_done", 32'(td_w[k]), 32'(td_m));
      fire_in = vld && ir_m;
      fire_rp = rpl && adv;
      drain   = vm && rdy;
      td_m    = drain && ((drained + 1) % (4 * rep) == 0);
      if (drain) begin
        $display("beat inst=%0d idx=%0d data=%0d", k, drained, dout_w[k]);
        drained++;
      end
      if (fire_in || fire_rp) begin
        loaded++;
        vm = 1'b1;
      end else if (rdy) begin
        vm = 1'b0;
      end
      if (fire_in) acc++;
      if (drained >= stop_at) begin
        post++;
        if (stop_at < n_out || post > 2) break;
      end
    end
    vin[k] = 1'b0;
    if (drained < stop_at) check_val("timeout", 32'(drained), 32'(stop_at));
  endtask

  initial begin
    checks = 0; failures = 0;
    vin = '0; rdy_in = '1; din_w = '0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("rst_valid", 32'(vout_w[k]), 32'd0);
      check_val("rst_data", 32'(dout_w[k]), 32'd0);
      check_val("rst_in_ready", 32'(in_rdy_w[k]), 32'd0);
      check_val("rst_tile_done", 32'(td_w[k]), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // REPEAT=3, continuous flow
    for (int i = 0; i < 4; i++) in_vec[i] = i + 1;
    for (int j = 0; j < 12; j++) exp_vec[j] = (j % 4) + 1;
    run(0, 3, 4, 12, 12, 0, 0);
    // REPEAT=3, downstream ready toggling
    run(0, 3, 4, 12, 12, 0, 1);

    // REPEAT=1, upstream gaps
    for (int i = 0; i < 4; i++) begin
      in_vec[i]  = i + 5;
      exp_vec[i] = i + 5;
    end
    run(1, 1, 4, 4, 4, 1, 0);

    // REPEAT=2, two back-to-back tiles
    for (int i = 0; i < 4; i++) begin
      in_vec[i]     = i + 1;
      in_vec[i + 4] = i + 9;
    end
    for (int t = 0; t < 2; t++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 4; b++)
          exp_vec[t*8 + p*4 + b] = in_vec[t*4 + b];
    run(2, 2, 8, 16, 16, 0, 0);

    // Reset mid-replay: pass 1, beat 2 held on the output
    for (int i = 0; i < 4; i++) in_vec[i] = i + 1;
    for (int j = 0; j < 12; j++) exp_vec[j] = (j % 4) + 1;
    run(0, 3, 4, 12, 6, 0, 0);
    @(negedge clk);
    #1;
    check_val("pre_rst_valid", 32'(vout_w[0]), 32'd1);
    check_val("pre_rst_data", 32'(dout_w[0]), 32'd3);
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", 32'(vout_w[0]), 32'd0);
    check_val("async_rst_data", 32'(dout_w[0]), 32'd0);
    check_val("async_rst_in_ready", 32'(in_rdy_w[0]), 32'd0);
    @(negedge clk); @(negedge clk);
    #1;
    check_val("held_rst_in_ready", 32'(in_rdy_w[0]), 32'd0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_rdy_w[0]), 32'd1);
    for (int i = 0; i < 4; i++) in_vec[i] = i + 20;
    for (int j = 0; j < 12; j++) exp_vec[j] = (j % 4) + 20;
    run(0, 3, 4, 12, 12, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
